// File: rtl/fetch_ctrl_if.sv
// Fetch-controller signal bundle: debug/hazard/branch inputs and PC/IF control outputs.
// master drives the commands and fetched word, slave is the controller itself.
interface fetch_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  cmd_valid;
    logic [1:0]            cmd;
    logic                  stall_in;
    logic                  branch_taken;
    logic [DATA_WIDTH-1:0] instr_in;
    logic                  pc_enable;
    logic                  pc_reset;
    logic                  if_flush;
    logic                  busy;
    logic                  halted;
    logic                  step_done;
    logic [CNT_WIDTH-1:0]  fetch_count;

    modport master (
        output cmd_valid, cmd, stall_in, branch_taken, instr_in,
        input  pc_enable, pc_reset, if_flush, busy, halted, step_done, fetch_count
    );

    modport slave (
        input  cmd_valid, cmd, stall_in, branch_taken, instr_in,
        output pc_enable, pc_reset, if_flush, busy, halted, step_done, fetch_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: run/step/pause/clear from the debug unit, stall and
// branch handling, HALT-opcode freeze, and a saturating count of PC advances.
module fetch_ctrl #(
    parameter int         DATA_WIDTH  = 32,
    parameter logic [5:0] HALT_OPCODE = 6'b111111,
    parameter int         CNT_WIDTH   = 32
) (
    input logic         clk,
    input logic         reset,
    fetch_ctrl_if.slave bus
);
    localparam logic [1:0] CMD_PAUSE = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic [2:0] {S_CLR, S_IDLE, S_RUN, S_STEP, S_HALT} state_t;

    state_t state;
    state_t next_state;
    logic   is_halt;
    logic   active;
    logic   clear;
    logic   pc_en;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_CLR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        is_halt    = (bus.instr_in[DATA_WIDTH-1 -: 6] == HALT_OPCODE);
        active     = (state == S_RUN) || (state == S_STEP);
        clear      = bus.cmd_valid && (bus.cmd == CMD_CLEAR);
        pc_en      = active && !bus.stall_in && !is_halt;
        next_state = state;
        if (clear) begin
            next_state = S_CLR;
        end else begin
            unique case (state)
                S_CLR:  next_state = S_IDLE;
                S_IDLE: begin
                    if (bus.cmd_valid && bus.cmd == CMD_RUN) begin
                        next_state = S_RUN;
                    end else if (bus.cmd_valid && bus.cmd == CMD_STEP) begin
                        next_state = S_STEP;
                    end
                end
                S_RUN: begin
                    if (is_halt && !bus.stall_in) begin
                        next_state = S_HALT;
                    end else if (bus.cmd_valid && bus.cmd == CMD_PAUSE) begin
                        next_state = S_IDLE;
                    end
                end
                S_STEP: begin
                    if (is_halt && !bus.stall_in) begin
                        next_state = S_HALT;
                    end else if (pc_en) begin
                        next_state = S_IDLE;
                    end
                end
                S_HALT: next_state = S_HALT;
                default: next_state = S_CLR;
            endcase
        end
    end

    always_comb begin
        bus.pc_enable = pc_en;
        bus.if_flush  = bus.branch_taken && active;
        bus.busy      = active;
        bus.halted    = (state == S_HALT);
    end

    // pc_reset and the counter clear track the state being entered, so both are
    // already in effect during the CLR cycle itself.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.pc_reset    <= 1'b1;
            bus.step_done   <= 1'b0;
            bus.fetch_count <= '0;
        end else begin
            bus.pc_reset  <= (next_state == S_CLR);
            bus.step_done <= (state == S_STEP) && pc_en && !clear;
            if (next_state == S_CLR) begin
                bus.fetch_count <= '0;
            end else if (pc_en && bus.fetch_count != '1) begin
                bus.fetch_count <= bus.fetch_count + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. Drives the PC register's enable and reset, and the IF flush line, from debug-unit commands (run, step, pause, clear), the hazard-unit stall, and branch resolution. It detects the HALT instruction on the fetched word and freezes fetch with the PC still pointing at it. It also keeps a count of PC advances for the debug unit to read back.

## Interface
- `DATA_WIDTH`, 32: fetched instruction width.
- `HALT_OPCODE`, 6'b111111: value of `instr_in[DATA_WIDTH-1:DATA_WIDTH-6]` that marks HALT.
- `CNT_WIDTH`, 32: width of `fetch_count`.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `cmd_valid`, in, 1: command strobe. One command per cycle, accepted every cycle.
- `cmd`, in, 2: 00 PAUSE, 01 RUN, 10 STEP, 11 CLEAR.
- `stall_in`, in, 1: hazard-unit stall. While high, the PC must not advance.
- `branch_taken`, in, 1: branch resolved taken; PC mux selects the branch target.
- `instr_in`, in, DATA_WIDTH: instruction currently fetched at the PC.
- `pc_enable`, out, 1: PC register load enable (combinational).
- `pc_reset`, out, 1: PC register clear (registered, active-high).
- `if_flush`, out, 1: squashes the IF/ID latch (combinational).
- `busy`, out, 1: high in RUN or STEP.
- `halted`, out, 1: high in HALT.
- `step_done`, out, 1: one-cycle pulse when a step completes (registered).
- `fetch_count`, out, CNT_WIDTH: number of cycles with `pc_enable`=1.

## Operation
- States:
  - CLR: `pc_reset`=1 and `fetch_count` is cleared. Lasts one cycle, then goes to IDLE.
  - IDLE: fetch frozen.
  - RUN: continuous fetch.
  - STEP: fetch exactly one instruction.
  - HALT: frozen until CLEAR.
- Command priority:
  - CLEAR is accepted in every state and has priority over all other conditions. Next state is CLR.
- IDLE transitions:
  - RUN goes to RUN; STEP goes to STEP.
  - PAUSE is a no-op.
- RUN transitions:
  - PAUSE goes to IDLE.
  - RUN and STEP are ignored.
- STEP behaviour:
  - All commands except CLEAR are ignored.
  - After the first cycle with `pc_enable`=1, go to IDLE and pulse `step_done` in the following cycle.
  - While stalled, remain in STEP.
- HALT:
  - `is_halt` = opcode field equals `HALT_OPCODE`.
  - In RUN or STEP with `is_halt`=1 and `stall_in`=0, go to HALT. `pc_enable` is 0 in that cycle, so the PC stays on the HALT word.
  - HALT ignores every command except CLEAR; `step_done` is not pulsed when a step ends in HALT.
- `pc_enable` = (RUN or STEP) and not `stall_in` and not `is_halt`.
- `if_flush` = `branch_taken` and (RUN or STEP). It asserts regardless of `stall_in`.
- `fetch_count`:
  - Increments by 1 on each clock edge with `pc_enable`=1.
  - Saturates at all-ones.
  - Cleared only in CLR and on reset.

## Timing
- `reset` low at a clock edge forces the state to CLR on that edge.
- Output values while `reset` is held low and in the CLR cycle:
  - `pc_reset`=1.
  - `pc_enable`=0, `if_flush`=0, `busy`=0, `halted`=0, `step_done`=0.
  - `fetch_count`=0.
- Reset release:
  - The first cycle after `reset` returns high is CLR.
  - IDLE follows; `pc_reset`=0 from then.
- Command latency:
  - A command sampled at edge N takes effect at edge N+1.
  - Example: RUN at edge N gives state RUN and `pc_enable`=1 in cycle N+1 (absent stall or halt).
- `pc_enable`, `if_flush`: combinational from state and inputs in the same cycle; no added latency.
- `step_done` rises in the cycle after the enabled step cycle and stays high exactly one cycle.
- Simultaneous events:
  - CLEAR with HALT detection in the same cycle: go to CLR.
  - PAUSE in RUN with stall: go to IDLE.
  - `branch_taken` with `is_halt`: `if_flush`=1, `pc_enable`=0, go to HALT.
- Reset mid-operation (RUN, STEP or HALT): return to CLR immediately; no `step_done` pulse.

## Test plan
- Reset sequence: hold `reset` low 3 cycles, then release. Required: `pc_reset`=1 through the first post-release cycle, then 0; `fetch_count`=0; `pc_enable`=0.
- Run/pause: RUN, 10 non-HALT cycles, then PAUSE. Required: `pc_enable` high 10 cycles, `fetch_count`=10, `busy` falls the cycle after PAUSE.
- Stalled step: STEP with `stall_in` high for 3 cycles, then low. Required: `pc_enable` low 3 cycles then high 1 cycle, `step_done` pulses once, `fetch_count`=1, state IDLE.
- Halt: RUN, instruction 4 has opcode 6'b111111. Required: `fetch_count`=3, `halted`=1, `pc_enable`=0; RUN and STEP ignored; CLEAR gives CLR, then IDLE with `fetch_count`=0.
- Branch: in RUN, `branch_taken`=1 with `stall_in`=1. Required: `if_flush`=1, `pc_enable`=0 in that same cycle.
- Saturation: with `CNT_WIDTH`=4, RUN for 20 cycles. Required: `fetch_count` holds at 15.
